// File: rtl/alu_pipe.sv
// Registered 16-op ALU with valid/ready handshake, status flags, accumulator operand
// and optional signed saturation for the add/sub classes.
module alu_pipe #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] ACC_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             use_acc,
    input  logic             acc_we,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic [WIDTH-1:0] acc
);

    localparam logic [WIDTH-1:0] ONE_C     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_C    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_C    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MAX_POS_C = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG_C = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] out_res_q, out_res_d;
    logic             out_valid_q, out_valid_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0] opa_s;
    logic [WIDTH-1:0] x_s, y_s, logic_res_s;
    logic             is_add_s, is_sub_s;
    logic [WIDTH:0]   sum_s, diff_s;
    logic [WIDTH-1:0] raw_s, final_s;
    logic             carry_s, ovf_s;
    logic             accept_s;

    assign opa_s    = use_acc ? acc_q : a;
    assign in_ready = !out_valid_q || out_ready;
    assign accept_s = in_valid && in_ready;

    // Opcode decode: arithmetic ops become x (+|-) y, the rest produce logic_res_s directly.
    always_comb begin
        x_s         = ZERO_C;
        y_s         = ZERO_C;
        is_add_s    = 1'b0;
        is_sub_s    = 1'b0;
        logic_res_s = ZERO_C;
        case (op)
            4'd0:  begin is_add_s = 1'b1; x_s = opa_s;  y_s = b;      end
            4'd1:  begin is_sub_s = 1'b1; x_s = opa_s;  y_s = b;      end
            4'd2:  begin is_sub_s = 1'b1; x_s = b;      y_s = opa_s;  end
            4'd3:  logic_res_s = ZERO_C;
            4'd4:  logic_res_s = ONE_C;
            4'd5:  logic_res_s = ONES_C;
            4'd6:  begin is_sub_s = 1'b1; x_s = ZERO_C; y_s = opa_s;  end
            4'd7:  begin is_sub_s = 1'b1; x_s = ZERO_C; y_s = b;      end
            4'd8:  logic_res_s = ~opa_s;
            4'd9:  logic_res_s = ~b;
            4'd10: begin is_add_s = 1'b1; x_s = opa_s;  y_s = ONE_C;  end
            4'd11: begin is_add_s = 1'b1; x_s = b;      y_s = ONE_C;  end
            4'd12: begin is_sub_s = 1'b1; x_s = opa_s;  y_s = ONE_C;  end
            4'd13: begin is_sub_s = 1'b1; x_s = b;      y_s = ONE_C;  end
            4'd14: logic_res_s = opa_s & b;
            4'd15: logic_res_s = opa_s | b;
            default: logic_res_s = ZERO_C;
        endcase
    end

    // The extra top bit is the carry for adds and the borrow (x < y) for subtracts.
    assign sum_s  = {1'b0, x_s} + {1'b0, y_s};
    assign diff_s = {1'b0, x_s} - {1'b0, y_s};

    // Result, carry/borrow and overflow selection; on overflow the true sign equals x's sign.
    always_comb begin
        raw_s   = logic_res_s;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        if (is_add_s) begin
            raw_s   = sum_s[WIDTH-1:0];
            carry_s = sum_s[WIDTH];
            ovf_s   = (x_s[WIDTH-1] == y_s[WIDTH-1]) && (sum_s[WIDTH-1] != x_s[WIDTH-1]);
        end else if (is_sub_s) begin
            raw_s   = diff_s[WIDTH-1:0];
            carry_s = diff_s[WIDTH];
            ovf_s   = (x_s[WIDTH-1] != y_s[WIDTH-1]) && (diff_s[WIDTH-1] != x_s[WIDTH-1]);
        end else begin
            raw_s   = logic_res_s;
            carry_s = 1'b0;
            ovf_s   = 1'b0;
        end
        if (sat && ovf_s) begin
            final_s = x_s[WIDTH-1] ? MIN_NEG_C : MAX_POS_C;
        end else begin
            final_s = raw_s;
        end
    end

    // Next state for the result stage and accumulator.
    always_comb begin
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        z_d         = z_q;
        n_d         = n_q;
        c_d         = c_q;
        v_d         = v_q;
        acc_d       = acc_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_res_d   = final_s;
            z_d         = (final_s == ZERO_C);
            n_d         = final_s[WIDTH-1];
            c_d         = carry_s;
            v_d         = ovf_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (accept_s && acc_we) begin
            acc_d = final_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // State registers; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_res_q   <= ZERO_C;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            acc_q       <= ACC_RST;
        end else begin
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            z_q         <= z_d;
            n_q         <= n_d;
            c_q         <= c_d;
            v_q         <= v_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = out_res_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: vector table, hand-written handshake/accumulator/reset
// sequences, and randomized traffic against an integer-arithmetic reference model.
module tb_alu_pipe;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         use_acc;
    logic         acc_we;
    logic         sat;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_z;
    logic         flag_n;
    logic         flag_c;
    logic         flag_v;
    logic [W-1:0] acc;

    alu_pipe #(.WIDTH(W), .ACC_RST(16'h0000)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .use_acc(use_acc), .acc_we(acc_we), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .acc(acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected state of the result stage, maintained at transaction level.
    bit         m_valid;
    logic [W-1:0] m_res;
    bit         m_z, m_n, m_c, m_v;
    logic [W-1:0] m_acc;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           sat;
        logic [W-1:0] res;
        logic [3:0]   zncv;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint sv(input logic [W-1:0] x);
        return longint'($signed(x));
    endfunction

    // Reference: compute the mathematically exact unsigned and signed results, then derive flags.
    function automatic void ref_op(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input bit st, output logic [W-1:0] r, output bit c, output bit v);
        longint ux, uy, sx, sy, tu, ts;
        int k;
        k = 0; ux = 0; uy = 0; sx = 0; sy = 0; r = '0; c = 1'b0; v = 1'b0;
        case (o)
            4'd0:  begin k = 1; ux = longint'(av); uy = longint'(bv); sx = sv(av); sy = sv(bv); end
            4'd1:  begin k = 2; ux = longint'(av); uy = longint'(bv); sx = sv(av); sy = sv(bv); end
            4'd2:  begin k = 2; ux = longint'(bv); uy = longint'(av); sx = sv(bv); sy = sv(av); end
            4'd3:  r = 16'h0000;
            4'd4:  r = 16'h0001;
            4'd5:  r = 16'hFFFF;
            4'd6:  begin k = 2; uy = longint'(av); sy = sv(av); end
            4'd7:  begin k = 2; uy = longint'(bv); sy = sv(bv); end
            4'd8:  r = ~av;
            4'd9:  r = ~bv;
            4'd10: begin k = 1; ux = longint'(av); uy = 1; sx = sv(av); sy = 1; end
            4'd11: begin k = 1; ux = longint'(bv); uy = 1; sx = sv(bv); sy = 1; end
            4'd12: begin k = 2; ux = longint'(av); uy = 1; sx = sv(av); sy = 1; end
            4'd13: begin k = 2; ux = longint'(bv); uy = 1; sx = sv(bv); sy = 1; end
            4'd14: r = av & bv;
            4'd15: r = av | bv;
            default: r = 16'h0000;
        endcase
        if (k != 0) begin
            tu = (k == 1) ? ux + uy : ux - uy;
            ts = (k == 1) ? sx + sy : sx - sy;
            c  = (k == 1) ? (tu > 65535) : (ux < uy);
            v  = (ts > 32767) || (ts < -32768);
            r  = tu[W-1:0];
            if (st && v) r = (ts > 0) ? 16'h7FFF : 16'h8000;
        end
    endfunction

    task automatic check_state();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("acc", 32'(acc), 32'(m_acc));
        if (m_valid) begin
            chk("result", 32'(result), 32'(m_res));
            chk("flags_zncv", 32'({flag_z, flag_n, flag_c, flag_v}), 32'({m_z, m_n, m_c, m_v}));
        end
    endtask

    // One clock cycle: drive, check in_ready, update model, clock, check registered outputs.
    task automatic step(input bit iv, input logic [3:0] o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input bit ua, input bit we, input bit st, input bit orr);
        logic [W-1:0] opa, r;
        bit c, v, rdy;
        in_valid = iv; op = o; a = ai; b = bi; use_acc = ua; acc_we = we; sat = st; out_ready = orr;
        #1;
        rdy = !m_valid || orr;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        if (iv && rdy) begin
            opa = ua ? m_acc : ai;
            ref_op(o, opa, bi, st, r, c, v);
            m_valid = 1'b1; m_res = r; m_z = (r == 16'h0000); m_n = r[W-1]; m_c = c; m_v = v;
            if (we) m_acc = r;
        end else if (m_valid && orr) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic do_reset(input bit iv, input bit orr);
        rst = 1'b1; in_valid = iv; out_ready = orr;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_valid = 1'b0; m_res = '0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0; m_acc = 16'h0000;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 4'd0;
        use_acc = 1'b0; acc_we = 1'b0; sat = 1'b0; out_ready = 1'b1;

        vecs[0]  = '{4'd0,  16'd64, 16'd32, 1'b0, 16'd96,   4'b0000};
        vecs[1]  = '{4'd1,  16'd64, 16'd32, 1'b0, 16'd32,   4'b0000};
        vecs[2]  = '{4'd2,  16'd64, 16'd32, 1'b0, 16'hFFE0, 4'b0110};
        vecs[3]  = '{4'd3,  16'd64, 16'd32, 1'b0, 16'd0,    4'b1000};
        vecs[4]  = '{4'd4,  16'd64, 16'd32, 1'b0, 16'd1,    4'b0000};
        vecs[5]  = '{4'd5,  16'd64, 16'd32, 1'b0, 16'hFFFF, 4'b0100};
        vecs[6]  = '{4'd6,  16'd64, 16'd32, 1'b0, 16'hFFC0, 4'b0110};
        vecs[7]  = '{4'd7,  16'd64, 16'd32, 1'b0, 16'hFFE0, 4'b0110};
        vecs[8]  = '{4'd8,  16'd64, 16'd32, 1'b0, 16'hFFBF, 4'b0100};
        vecs[9]  = '{4'd9,  16'd64, 16'd32, 1'b0, 16'hFFDF, 4'b0100};
        vecs[10] = '{4'd10, 16'd64, 16'd32, 1'b0, 16'd65,   4'b0000};
        vecs[11] = '{4'd11, 16'd64, 16'd32, 1'b0, 16'd33,   4'b0000};
        vecs[12] = '{4'd12, 16'd64, 16'd32, 1'b0, 16'd63,   4'b0000};
        vecs[13] = '{4'd13, 16'd64, 16'd32, 1'b0, 16'd31,   4'b0000};
        vecs[14] = '{4'd14, 16'd64, 16'd32, 1'b0, 16'd0,    4'b1000};
        vecs[15] = '{4'd15, 16'd64, 16'd32, 1'b0, 16'd96,   4'b0000};
        vecs[16] = '{4'd0,  16'h7FFF, 16'd1, 1'b0, 16'h8000, 4'b0101};
        vecs[17] = '{4'd0,  16'h7FFF, 16'd1, 1'b1, 16'h7FFF, 4'b0001};
        vecs[18] = '{4'd1,  16'h8000, 16'd1, 1'b1, 16'h8000, 4'b0101};
        vecs[19] = '{4'd12, 16'h0000, 16'd0, 1'b0, 16'hFFFF, 4'b0110};
        vecs[20] = '{4'd10, 16'hFFFF, 16'd0, 1'b0, 16'h0000, 4'b1010};

        do_reset(1'b0, 1'b1);

        // Table: one op per cycle, result visible after the accepting edge.
        for (int i = 0; i < 21; i++) begin
            step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, vecs[i].sat, 1'b1);
            chk($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].res));
            chk($sformatf("vec%0d_flags", i), 32'({flag_z, flag_n, flag_c, flag_v}), 32'(vecs[i].zncv));
        end

        // Accumulator chain.
        do_reset(1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 4'd10, 16'hAAAA, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
            chk("acc_chain_result", 32'(result), 32'(i));
        end
        chk("acc_chain_acc", 32'(acc), 32'd3);
        step(1'b1, 4'd14, 16'h5555, 16'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("acc_and_result", 32'(result), 32'd2);
        chk("acc_and_acc", 32'(acc), 32'd3);

        // Backpressure: held result, stalled op accepted when out_ready returns.
        step(1'b1, 4'd0, 16'd5, 16'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'd15, 16'd3, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_held_result", 32'(result), 32'd12);
        end
        step(1'b1, 4'd15, 16'd3, 16'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_new_result", 32'(result), 32'd7);
        step(1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Reset while a result is stalled.
        step(1'b1, 4'd0, 16'd1, 16'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 4'd0, 16'd9, 16'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        do_reset(1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 4'($urandom), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 16-op combinational ALU.
- Keeps the same 4-bit opcode map and adds:
  - generic WIDTH;
  - a valid/ready handshake on input and output;
  - a one-stage result register holding status flags;
  - an internal accumulator that can stand in for operand a;
  - an optional signed-saturation mode.
- Sits between the register-file read stage and writeback.

Parameters:
- WIDTH, 16, operand/result/accumulator width in bits (>=4).
- ACC_RST, 0, accumulator reset value (WIDTH bits).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept an operation this cycle
- a  in  WIDTH  operand a
- b  in  WIDTH  operand b
- op  in  4  opcode
- use_acc  in  1  1 = use accumulator in place of a
- acc_we  in  1  1 = write result into accumulator on accept
- sat  in  1  1 = signed saturation for add/sub-class ops
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  downstream consumes the result
- result  out  WIDTH  registered result
- flag_z  out  1  result == 0
- flag_n  out  1  result MSB
- flag_c  out  1  carry (add class) / borrow (sub class), else 0
- flag_v  out  1  signed overflow before saturation, else 0
- acc  out  WIDTH  current accumulator value

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, result=0, all flags=0, acc=ACC_RST. in_ready=1 in the cycle after reset.
- Reset mid-operation: a pending result is discarded and not delivered. Reset has priority over everything else.
- Operand: A = use_acc ? acc : a.
- Opcode map, all arithmetic mod 2^WIDTH:
  - 0: A+b
  - 1: A-b
  - 2: b-A
  - 3: 0
  - 4: 1
  - 5: all ones
  - 6: 0-A
  - 7: 0-b
  - 8: ~A
  - 9: ~b
  - 10: A+1
  - 11: b+1
  - 12: A-1
  - 13: b-1
  - 14: A&b
  - 15: A|b
- Op classes:
  - Add class: 0, 10, 11. flag_c = unsigned carry-out.
  - Sub class: 1, 2, 6, 7, 12, 13. flag_c = borrow, i.e. 1 when unsigned minuend < subtrahend. So op6 gives C=(A!=0) and op12 gives C=(A==0).
  - Other ops: flag_c=0 and flag_v=0.
- flag_v: two's-complement overflow of the add/sub computation, computed on the unsaturated result.
- Saturation, when sat=1 and flag_v=1 for add/sub ops:
  - result = max positive (0111..1) when the true result is positive.
  - result = min negative (1000..0) when the true result is negative.
  - flag_v stays 1.
  - sat has no effect on the other ops.
- flag_z and flag_n are computed on the final (post-saturation) result.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept happens when in_valid && in_ready.
  - On accept, result, flags and out_valid=1 are registered at the next edge. Latency is 1 cycle.
  - Output transfer happens when out_valid && out_ready. With no new accept in that cycle, out_valid goes to 0.
  - Simultaneous transfer and accept: the new result replaces the old in the same edge and out_valid stays 1. Throughput is 1 op per cycle.
  - While out_valid && !out_ready: result, flags and out_valid are held stable, in_ready=0, and inputs are ignored.
- Accumulator:
  - On accept with acc_we=1, acc is loaded with the final result at the same edge as result.
  - acc never changes otherwise.
  - Back-to-back use_acc ops see the accumulator value written by the previous accepted op (no hazard stall needed).
- No X propagation: every output is defined in every cycle after reset.

Test Plan:
- WIDTH=16, a=64, b=32, op swept 0..15 with out_ready=1 → results 96, 32, 0xFFE0, 0, 1, 0xFFFF, 0xFFC0, 0xFFE0, 0xFFBF, 0xFFDF, 65, 33, 63, 31, 0, 96, one per cycle after 1-cycle latency; op2 gives C=1, N=1.
- a=0x7FFF, b=1, op0: sat=0 → 0x8000, V=1, N=1, C=0; sat=1 → 0x7FFF, V=1, N=0. Then a=0x8000, b=1, op1, sat=1 → 0x8000, V=1.
- a=0, op12 → 0xFFFF, C=1, N=1; a=0xFFFF, op10 → 0, C=1, Z=1.
- Accumulator: after reset acc=0; three accepted op10 with use_acc=1, acc_we=1 → results 1, 2, 3 on consecutive cycles, acc=3; then op14 with b=2, use_acc=1, acc_we=0 → result 2, acc stays 3.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, result held unchanged; raise out_ready → old result transfers and the held op is accepted in the same cycle, its result appears on the next edge.
- Reset asserted while out_valid=1 and out_ready=0 → next cycle out_valid=0, result=0, flags=0, acc=ACC_RST, in_ready=1.
